// File: rtl/cpu_divider_if.sv
// Handshake and operand/result bundle between the execute stage and cpu_divider.
interface cpu_divider_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    logic             is_signed;
    logic             want_rem;
    logic             abort;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    // Requester side: the control unit issuing divide operations.
    modport master (
        output start,
        output is_signed,
        output want_rem,
        output abort,
        output operand_a,
        output operand_b,
        input  ready,
        input  done,
        input  result
    );

    // Divider side.
    modport slave (
        input  start,
        input  is_signed,
        input  want_rem,
        input  abort,
        input  operand_a,
        input  operand_b,
        output ready,
        output done,
        output result
    );

endinterface : cpu_divider_if

// File: rtl/cpu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes and fixes the signs up in a final cycle, so the
// latency is WIDTH+1 clocks regardless of operand values.
module cpu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_divider_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [WIDTH-1:0]   rem_q,       rem_d;
    logic [WIDTH-1:0]   dvd_q,       dvd_d;
    logic [WIDTH-1:0]   dsr_q,       dsr_d;
    logic [WIDTH-1:0]   orig_a_q,    orig_a_d;
    logic               is_signed_q, is_signed_d;
    logic               want_rem_q,  want_rem_d;
    logic               sign_q_q,    sign_q_d;
    logic               sign_r_q,    sign_r_d;
    logic               div_zero_q,  div_zero_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               done_q,      done_d;

    logic [WIDTH:0]     shifted_c;
    logic               q_bit_c;
    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   quo_val_c;
    logic [WIDTH-1:0]   rem_val_c;

    // Two's complement negation modulo 2^WIDTH (MIN stays MIN).
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Shift the next dividend bit into the partial remainder and trial-compare with the divisor.
    always_comb begin
        shifted_c = {rem_q, dvd_q[WIDTH-1]};
        q_bit_c   = (shifted_c >= {1'b0, dsr_q});
    end

    // Operand sign detection for magnitude capture.
    always_comb begin
        a_neg_c = bus.is_signed & bus.operand_a[WIDTH-1];
        b_neg_c = bus.is_signed & bus.operand_b[WIDTH-1];
    end

    // Final value selection: sign correction, then the divide-by-zero override.
    always_comb begin
        quo_val_c = (is_signed_q && sign_q_q) ? negate(dvd_q) : dvd_q;
        rem_val_c = (is_signed_q && sign_r_q) ? negate(rem_q) : rem_q;
        if (div_zero_q) begin
            quo_val_c = '1;
            rem_val_c = orig_a_q;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        orig_a_d    = orig_a_q;
        is_signed_d = is_signed_q;
        want_rem_d  = want_rem_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        div_zero_d  = div_zero_q;
        result_d    = result_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    is_signed_d = bus.is_signed;
                    want_rem_d  = bus.want_rem;
                    dvd_d       = a_neg_c ? negate(bus.operand_a) : bus.operand_a;
                    dsr_d       = b_neg_c ? negate(bus.operand_b) : bus.operand_b;
                    orig_a_d    = bus.operand_a;
                    sign_q_d    = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                    sign_r_d    = bus.operand_a[WIDTH-1];
                    div_zero_d  = (bus.operand_b == '0);
                    rem_d       = '0;
                    count_d     = CNT_W'(WIDTH);
                    state_d     = ITER;
                end
            end

            ITER: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = q_bit_c ? WIDTH'(shifted_c - {1'b0, dsr_q})
                                      : shifted_c[WIDTH-1:0];
                    dvd_d   = {dvd_q[WIDTH-2:0], q_bit_c};
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    result_d = want_rem_q ? rem_val_c : quo_val_c;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            orig_a_q    <= '0;
            is_signed_q <= 1'b0;
            want_rem_q  <= 1'b0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            orig_a_q    <= orig_a_d;
            is_signed_q <= is_signed_d;
            want_rem_q  <= want_rem_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            div_zero_q  <= div_zero_d;
            result_q    <= result_d;
            done_q      <= done_d;
        end
    end

endmodule : cpu_divider

// File: tb/tb_cpu_divider.sv
// Self-checking bench for cpu_divider: directed RV32M cases, control corners and
// a randomized back-to-back sweep against an arithmetic reference model.
module tb_cpu_divider;

    localparam int unsigned WIDTH   = 32;
    localparam int          LAT     = 33;
    localparam int          N_SWEEP = 1000;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    cpu_divider_if #(.WIDTH(WIDTH)) bus ();

    cpu_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain RV32M semantics.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input bit r);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        if (b == 32'h0) return r ? a : 32'hFFFF_FFFF;
        if (!s) return r ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return r ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            6:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present an operation for one accepting edge, then scramble the inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit r);
        bus.operand_a = a;
        bus.operand_b = b;
        bus.is_signed = s;
        bus.want_rem  = r;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = 32'($urandom);
        bus.operand_b = 32'($urandom);
        bus.is_signed = 1'($urandom);
        bus.want_rem  = 1'($urandom);
    endtask

    // Wait for done; lat counts edges after the accepting edge, -1 on timeout.
    task automatic wait_done(output logic [31:0] res, output int lat);
        res = 32'h0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                res = bus.result;
                lat = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.is_signed = 1'b0;
        bus.want_rem  = 1'b0;
        bus.operand_a = 32'h0;
        bus.operand_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [14];
        logic [31:0] tb [14];
        bit          ts [14];
        bit          tr [14];
        logic [31:0] te [14];
        logic [31:0] res;
        int          lat;
        ta = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
               32'd5, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFB,
               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        tb = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
               32'd0, 32'd0, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'd9, 32'd1};
        ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        te = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB,
               32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0, 32'h0};
        for (int i = 0; i < 14; i++) begin
            issue(ta[i], tb[i], ts[i], tr[i]);
            wait_done(res, lat);
            checks++;
            if (res !== te[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] a=%h b=%h s=%0d r=%0d got=%h exp=%h",
                         i, ta[i], tb[i], ts[i], tr[i], res, te[i]);
            end
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            checks++;
            if (bus.ready !== 1'b1) begin errors++; $display("FAIL directed_ready_at_done[%0d] got=%b exp=1", i, bus.ready); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0) begin errors++; $display("FAIL directed_done_width[%0d] got=%b exp=0", i, bus.done); end
            checks++;
            if (bus.result !== te[i]) begin errors++; $display("FAIL directed_result_hold[%0d] got=%h exp=%h", i, bus.result, te[i]); end
        end
    endtask

    task automatic test_control();
        int          dones;
        int          dcyc;
        logic [31:0] dres;
        logic [31:0] res;
        int          lat;

        // start while busy is ignored
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        dones = 0; dcyc = 0; dres = 32'h0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin dones++; dcyc = cyc; dres = bus.result; end
            if (cyc == 9) begin
                checks++;
                if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", bus.ready); end
                bus.operand_a = 32'd500; bus.operand_b = 32'd3; bus.start = 1'b1;
            end
            if (cyc == 10) bus.start = 1'b0;
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        checks++;
        if (dcyc !== LAT) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", dcyc, LAT); end
        checks++;
        if (dres !== 32'd14) begin errors++; $display("FAIL busy_result got=%h exp=%h", dres, 32'd14); end

        // abort mid-operation
        issue(32'd1000, 32'd3, 1'b0, 1'b0);
        dones = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
            if (cyc == 14) bus.abort = 1'b1;
            if (cyc == 15) begin
                bus.abort = 1'b0;
                checks++;
                if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus.ready); end
            end
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_done_count got=%0d exp=0", dones); end
        checks++;
        if (bus.result !== 32'd14) begin errors++; $display("FAIL abort_result got=%h exp=%h", bus.result, 32'd14); end

        // abort in IDLE blocks a simultaneous start
        bus.operand_a = 32'd9; bus.operand_b = 32'd2; bus.is_signed = 1'b0; bus.want_rem = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL idle_abort_ready got=%b exp=1", bus.ready); end
        dones = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL idle_abort_done_count got=%0d exp=0", dones); end

        // asynchronous reset mid-operation
        issue(32'd100, 32'd7, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.ready); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h exp=0", bus.result); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_done(res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL postrst_result got=%h exp=%h", res, 32'hFFFF_FFFD); end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL postrst_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp, res;
        bit          s, r;
        int          lat;

        issue(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(res, lat);
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL b2b_first got=%h exp=%h", res, 32'd14); end
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done(res, lat);
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL b2b_second got=%h exp=%h", res, 32'd2); end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end

        a = rand_op(); b = rand_op(); s = 1'($urandom); r = 1'($urandom);
        exp = ref_div(a, b, s, r);
        issue(a, b, s, r);
        for (int i = 0; i < N_SWEEP; i++) begin
            wait_done(res, lat);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL sweep_result[%0d] a=%h b=%h s=%0d r=%0d got=%h exp=%h", i, a, b, s, r, res, exp);
            end
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            if (lat < 0) break;
            if (i < N_SWEEP - 1) begin
                a = rand_op(); b = rand_op(); s = 1'($urandom); r = 1'($urandom);
                exp = ref_div(a, b, s, r);
                issue(a, b, s, r);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_control();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_divider
